cas_block_sched: RTL and testbench

- Sequencer for the cassette byte serializer.
- Takes a block request from the host/loader side (type, length, buffered data) and drives the serializer's start/din/done handshake to emit one complete tape block, byte by byte.
- Block format: leader, sync 0x3C, type, length, data, checksum, trailer 0x55.
- Sits between the cassette buffer RAM and the square-wave byte generator that feeds the audio/tape output.

---
 rtl/cas_block_sched.sv | 234 +++++++++++++++++++++++
 tb/tb_cas_block_sched.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cas_block_sched.sv
// cas_block_sched: sequences one cassette tape block into the byte serializer.
// Block layout: FILL_BYTE x LEADER_LEN, SYNC_BYTE, type, len, data[0..len-1],
// checksum (type + len + data, modulo 256), FILL_BYTE.
// Optional build macro CAS_ABORT_EN adds an abort input and a blk_err output.
// An abort cuts the block short once the byte in flight has finished.
module cas_block_sched #(
  parameter int unsigned LEADER_LEN = 128,
  parameter logic [7:0]  SYNC_BYTE  = 8'h3C,
  parameter logic [7:0]  FILL_BYTE  = 8'h55
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       blk_req,
  input  logic [7:0] blk_type,
  input  logic [7:0] blk_len,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       gen_start,
  output logic [7:0] gen_din,
  input  logic       gen_done,
  output logic       busy,
  output logic       blk_done
`ifdef CAS_ABORT_EN
  ,
  input  logic       abort,
  output logic       blk_err
`endif
);

  localparam logic [7:0] LEADER_CNT = 8'(LEADER_LEN);

  typedef enum logic [3:0] {
    S_IDLE, S_LEADER, S_SYNC, S_TYPE, S_LEN, S_FETCH, S_DATA, S_CSUM, S_TRAILER
  } state_e;

  // Per-byte handshake: ISSUE computes the byte, START is the cycle gen_start
  // is high, GUARD ignores a done flag that has not dropped yet, WAIT looks
  // for completion.
  typedef enum logic [1:0] {
    PH_ISSUE, PH_START, PH_GUARD, PH_WAIT
  } phase_e;

  state_e     state_q, state_d;
  phase_e     phase_q, phase_d;
  logic [7:0] type_q, type_d;
  logic [7:0] len_q, len_d;
  logic [7:0] csum_q, csum_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] rd_addr_q, rd_addr_d;
  logic       gen_start_q, gen_start_d;
  logic [7:0] gen_din_q, gen_din_d;
  logic       busy_q, busy_d;
  logic       blk_done_q, blk_done_d;
  logic       sending;
  logic       byte_done;
  logic [7:0] byte_val;
`ifdef CAS_ABORT_EN
  logic       abort_q, abort_d;
  logic       blk_err_q, blk_err_d;
`endif

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_ISSUE;
      type_q      <= 8'h00;
      len_q       <= 8'h00;
      csum_q      <= 8'h00;
      cnt_q       <= 8'h00;
      rd_addr_q   <= 8'h00;
      gen_start_q <= 1'b0;
      gen_din_q   <= 8'h00;
      busy_q      <= 1'b0;
      blk_done_q  <= 1'b0;
`ifdef CAS_ABORT_EN
      abort_q     <= 1'b0;
      blk_err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      phase_q     <= phase_d;
      type_q      <= type_d;
      len_q       <= len_d;
      csum_q      <= csum_d;
      cnt_q       <= cnt_d;
      rd_addr_q   <= rd_addr_d;
      gen_start_q <= gen_start_d;
      gen_din_q   <= gen_din_d;
      busy_q      <= busy_d;
      blk_done_q  <= blk_done_d;
`ifdef CAS_ABORT_EN
      abort_q     <= abort_d;
      blk_err_q   <= blk_err_d;
`endif
    end
  end

  // Byte handshake, next-state sequencing and checksum accumulation.
  always_comb begin
    // NOTE: every variable gets a default first, so no path infers a latch.
    state_d     = state_q;
    phase_d     = phase_q;
    type_d      = type_q;
    len_d       = len_q;
    csum_d      = csum_q;
    cnt_d       = cnt_q;
    rd_addr_d   = rd_addr_q;
    gen_start_d = 1'b0;
    gen_din_d   = gen_din_q;
    busy_d      = busy_q;
    blk_done_d  = 1'b0;
    byte_done   = 1'b0;
    byte_val    = FILL_BYTE;
`ifdef CAS_ABORT_EN
    abort_d     = abort_q | (abort & (state_q != S_IDLE));
    blk_err_d   = 1'b0;
`endif

    // busy stays high through the blk_done cycle so a request there is ignored.
    if (blk_done_q) busy_d = 1'b0;

    case (state_q)
      S_SYNC:  byte_val = SYNC_BYTE;
      S_TYPE:  byte_val = type_q;
      S_LEN:   byte_val = len_q;
      S_DATA:  byte_val = rd_data;
      S_CSUM:  byte_val = csum_q;
      default: byte_val = FILL_BYTE;
    endcase

    sending = (state_q != S_IDLE) && (state_q != S_FETCH);

    if (sending) begin
      case (phase_q)
        PH_ISSUE: begin
          gen_start_d = 1'b1;
          gen_din_d   = byte_val;
          phase_d     = PH_START;
        end
        PH_START: phase_d = PH_GUARD;
        PH_GUARD: phase_d = PH_WAIT;
        default: begin
          if (gen_done) begin
            byte_done = 1'b1;
            phase_d   = PH_ISSUE;
          end
        end
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (blk_req && !busy_q) begin
          type_d    = blk_type;
          len_d     = blk_len;
          csum_d    = 8'h00;
          cnt_d     = LEADER_CNT;
          rd_addr_d = 8'h00;
          busy_d    = 1'b1;
          phase_d   = PH_ISSUE;
          state_d   = S_LEADER;
`ifdef CAS_ABORT_EN
          abort_d   = 1'b0;
`endif
        end
      end
      S_LEADER: begin
        if (byte_done) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = S_SYNC;
        end
      end
      S_SYNC: if (byte_done) state_d = S_TYPE;
      S_TYPE: begin
        if (byte_done) begin
          csum_d  = csum_q + type_q;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (byte_done) begin
          csum_d    = csum_q + len_q;
          rd_addr_d = 8'h00;
          state_d   = (len_q == 8'h00) ? S_CSUM : S_FETCH;
        end
      end
      // rd_addr has been stable for a cycle; rd_data is valid in DATA.
      S_FETCH: state_d = S_DATA;
      S_DATA: begin
        if (byte_done) begin
          csum_d = csum_q + gen_din_q;
          if (rd_addr_q == len_q - 8'd1) begin
            state_d = S_CSUM;
          end else begin
            rd_addr_d = rd_addr_q + 8'd1;
            state_d   = S_FETCH;
          end
        end
      end
      S_CSUM: if (byte_done) state_d = S_TRAILER;
      S_TRAILER: begin
        if (byte_done) begin
          blk_done_d = 1'b1;
          rd_addr_d  = 8'h00;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef CAS_ABORT_EN
    // A pending abort ends the block as soon as the byte in flight completes.
    if (byte_done && abort_d) begin
      blk_done_d = 1'b1;
      blk_err_d  = 1'b1;
      abort_d    = 1'b0;
      rd_addr_d  = 8'h00;
      state_d    = S_IDLE;
    end
`endif
  end

  assign rd_addr   = rd_addr_q;
  assign gen_start = gen_start_q;
  assign gen_din   = gen_din_q;
  assign busy      = busy_q;
  assign blk_done  = blk_done_q;
`ifdef CAS_ABORT_EN
  assign blk_err   = blk_err_q;
`endif

endmodule

// File: tb/tb_cas_block_sched.sv
// tb_cas_block_sched: directed bench for cas_block_sched with LEADER_LEN=4.
// Includes a serializer model and a synchronous buffer RAM model.
module tb_cas_block_sched;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       blk_req = 1'b0;
  logic [7:0] blk_type = 8'h00;
  logic [7:0] blk_len = 8'h00;
  logic [7:0] rd_addr;
  logic [7:0] rd_data = 8'h00;
  logic       gen_start;
  logic [7:0] gen_din;
  logic       gen_done;
  logic       busy;
  logic       blk_done;
`ifdef CAS_ABORT_EN
  logic       abort = 1'b0;
  logic       blk_err;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  // Monitor state
  byte_q_t    seq;
  int         n_start = 0;
  int         n_blkdone = 0;
  int         rd_nz = 0;
  int         early_start = 0;
  int         din_glitch = 0;
  int         n_errp = 0;
  logic [7:0] last_din = 8'h00;
  bit         started = 1'b0;

  // Serializer model state
  int  ser_lat = 3;
  bit  stuck_mode = 1'b0;
  int  ser_cnt = 0;
  bit  ser_hold = 1'b0;
  logic [7:0] mem [256];

  cas_block_sched #(.LEADER_LEN(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .blk_req   (blk_req),
    .blk_type  (blk_type),
    .blk_len   (blk_len),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .gen_start (gen_start),
    .gen_din   (gen_din),
    .gen_done  (gen_done),
    .busy      (busy),
    .blk_done  (blk_done)
`ifdef CAS_ABORT_EN
    ,
    .abort     (abort),
    .blk_err   (blk_err)
`endif
  );

  always #5 clk = ~clk;

  // Buffer RAM: data valid one clock after the address.
  always @(posedge clk) rd_data <= mem[rd_addr];

  // Serializer: done drops after start (one clk later in stuck mode),
  // then rises again after ser_lat further clocks.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gen_done <= 1'b1;
      ser_cnt  <= 0;
      ser_hold <= 1'b0;
    end else if (gen_start) begin
      ser_cnt  <= ser_lat;
      ser_hold <= stuck_mode;
      if (!stuck_mode) gen_done <= 1'b0;
    end else if (ser_hold) begin
      ser_hold <= 1'b0;
      gen_done <= 1'b0;
    end else if (!gen_done) begin
      if (ser_cnt == 0) gen_done <= 1'b1;
      else ser_cnt <= ser_cnt - 1;
    end
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      started = 1'b0;
    end else begin
      if (gen_start) begin
        seq.push_back(gen_din);
        n_start++;
        if (!gen_done) early_start++;
        last_din = gen_din;
        started  = 1'b1;
      end else if (started && gen_din !== last_din) begin
        din_glitch++;
      end
      if (blk_done) n_blkdone++;
`ifdef CAS_ABORT_EN
      if (blk_done && blk_err) n_errp++;
`endif
      if (rd_addr != 8'h00) rd_nz++;
    end
  end

  task automatic clear_mon();
    seq.delete();
    n_start = 0; n_blkdone = 0; rd_nz = 0;
    early_start = 0; din_glitch = 0; n_errp = 0;
  endtask

  task automatic run_block(input logic [7:0] t, input logic [7:0] l, output bit ok);
    clear_mon();
    @(negedge clk);
    blk_type = t; blk_len = l; blk_req = 1'b1;
    @(negedge clk);
    blk_req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (blk_done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (gen_start !== 1'b0) begin n_mis++; $display("FAIL reset_gen_start got %b want 0", gen_start); end
    n_cmp++; if (gen_din !== 8'h00) begin n_mis++; $display("FAIL reset_gen_din got %h want 00", gen_din); end
    n_cmp++; if (rd_addr !== 8'h00) begin n_mis++; $display("FAIL reset_rd_addr got %h want 00", rd_addr); end
    n_cmp++; if (blk_done !== 1'b0) begin n_mis++; $display("FAIL reset_blk_done got %b want 0", blk_done); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_basic(input string name);
    bit ok;
    byte_q_t exp;
    exp = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h3C, 8'h00, 8'h03,
            8'h10, 8'h20, 8'h30, 8'h63, 8'h55};
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30;
    run_block(8'h00, 8'h03, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL %s_timeout no blk_done within budget", name); end
    n_cmp++;
    if (seq.size() != exp.size()) begin
      n_mis++; $display("FAIL %s_len got %0d bytes want %0d", name, seq.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_cmp++;
        if (seq[i] !== exp[i]) begin
          n_mis++; $display("FAIL %s_byte%0d got %h want %h", name, i, seq[i], exp[i]);
        end
      end
    end
    n_cmp++; if (n_start != 12) begin n_mis++; $display("FAIL %s_starts got %0d want 12", name, n_start); end
    n_cmp++; if (n_blkdone != 1) begin n_mis++; $display("FAIL %s_blk_done got %0d want 1", name, n_blkdone); end
    n_cmp++; if (early_start != 0) begin n_mis++; $display("FAIL %s_early_start got %0d want 0", name, early_start); end
    n_cmp++; if (din_glitch != 0) begin n_mis++; $display("FAIL %s_din_hold got %0d changes want 0", name, din_glitch); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL %s_busy_end got %b want 0", name, busy); end
  endtask

  task automatic test_len0();
    bit ok;
    byte_q_t exp;
    exp = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h3C, 8'hFF, 8'h00, 8'hFF, 8'h55};
    run_block(8'hFF, 8'h00, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL len0_timeout no blk_done within budget"); end
    n_cmp++;
    if (seq.size() != exp.size()) begin
      n_mis++; $display("FAIL len0_len got %0d bytes want %0d", seq.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_cmp++;
        if (seq[i] !== exp[i]) begin
          n_mis++; $display("FAIL len0_byte%0d got %h want %h", i, seq[i], exp[i]);
        end
      end
    end
    n_cmp++; if (rd_nz != 0) begin n_mis++; $display("FAIL len0_rd_addr got %0d nonzero samples want 0", rd_nz); end
  endtask

  task automatic test_csum_wrap();
    bit ok;
    // 0x80 + 0x02 + 0xC0 + 0x41 = 0x183 -> 0x83 modulo 256
    mem[0] = 8'hC0; mem[1] = 8'h41;
    run_block(8'h80, 8'h02, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL wrap_timeout no blk_done within budget"); end
    n_cmp++;
    if (seq.size() != 11) begin
      n_mis++; $display("FAIL wrap_len got %0d bytes want 11", seq.size());
    end else begin
      n_cmp++; if (seq[7] !== 8'hC0) begin n_mis++; $display("FAIL wrap_d0 got %h want c0", seq[7]); end
      n_cmp++; if (seq[8] !== 8'h41) begin n_mis++; $display("FAIL wrap_d1 got %h want 41", seq[8]); end
      n_cmp++; if (seq[9] !== 8'h83) begin n_mis++; $display("FAIL wrap_csum got %h want 83", seq[9]); end
    end
  endtask

  task automatic test_stuck_done();
    stuck_mode = 1'b1;
    test_basic("stuck");
    stuck_mode = 1'b0;
  endtask

  task automatic test_req_ignored();
    bit ok;
    byte_q_t exp;
    exp = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h3C, 8'h00, 8'h03,
            8'h10, 8'h20, 8'h30, 8'h63, 8'h55};
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30;
    clear_mon();
    @(negedge clk);
    blk_type = 8'h00; blk_len = 8'h03; blk_req = 1'b1;
    @(negedge clk);
    blk_req = 1'b0;
    // Wait for the first data byte, then re-request mid-DATA.
    for (int i = 0; i < 2000 && n_start < 8; i++) @(negedge clk);
    blk_type = 8'hAA; blk_len = 8'h07; blk_req = 1'b1;
    @(negedge clk);
    blk_req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (blk_done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    // Request in the blk_done cycle itself.
    n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL ign_busy_at_done got %b want 1", busy); end
    blk_req = 1'b1;
    @(negedge clk);
    blk_req = 1'b0;
    repeat (60) @(negedge clk);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL ign_timeout no blk_done within budget"); end
    n_cmp++; if (n_start != 12) begin n_mis++; $display("FAIL ign_starts got %0d want 12", n_start); end
    n_cmp++; if (n_blkdone != 1) begin n_mis++; $display("FAIL ign_blk_done got %0d want 1", n_blkdone); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL ign_busy_end got %b want 0", busy); end
    n_cmp++;
    if (seq.size() != exp.size()) begin
      n_mis++; $display("FAIL ign_len got %0d bytes want %0d", seq.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_cmp++;
        if (seq[i] !== exp[i]) begin
          n_mis++; $display("FAIL ign_byte%0d got %h want %h", i, seq[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
    clear_mon();
    @(negedge clk);
    blk_type = 8'h07; blk_len = 8'h04; blk_req = 1'b1;
    @(negedge clk);
    blk_req = 1'b0;
    // Second data byte in flight: leader(4) + sync + type + len + d0 + d1.
    for (int i = 0; i < 2000 && n_start < 9; i++) @(negedge clk);
    n_cmp++; if (n_start != 9) begin n_mis++; $display("FAIL rstmid_reach got %0d starts want 9", n_start); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_cmp++; if (rd_addr !== 8'h00) begin n_mis++; $display("FAIL rstmid_rd_addr got %h want 00", rd_addr); end
    n_cmp++; if (gen_start !== 1'b0) begin n_mis++; $display("FAIL rstmid_gen_start got %b want 0", gen_start); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    n_cmp++; if (n_blkdone != 0) begin n_mis++; $display("FAIL rstmid_blk_done got %0d want 0", n_blkdone); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL rstmid_idle got busy %b want 0", busy); end
  endtask

`ifdef CAS_ABORT_EN
  task automatic test_abort();
    bit ok;
    clear_mon();
    @(negedge clk);
    blk_type = 8'h12; blk_len = 8'h01; blk_req = 1'b1;
    @(negedge clk);
    blk_req = 1'b0;
    for (int i = 0; i < 2000 && n_start < 2; i++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (blk_done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL abort_timeout no blk_done within budget"); end
    n_cmp++; if (blk_err !== 1'b1) begin n_mis++; $display("FAIL abort_blk_err got %b want 1", blk_err); end
    repeat (30) @(negedge clk);
    n_cmp++; if (seq.size() != 2) begin n_mis++; $display("FAIL abort_bytes got %0d want 2", seq.size()); end
    n_cmp++; if (n_errp != 1) begin n_mis++; $display("FAIL abort_err_pulses got %0d want 1", n_errp); end
    n_cmp++; if (blk_err !== 1'b0) begin n_mis++; $display("FAIL abort_err_clear got %b want 0", blk_err); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL abort_busy got %b want 0", busy); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_basic("basic");
    test_len0();
    test_csum_wrap();
    test_stuck_done();
    test_req_ignored();
    test_reset_mid();
    test_basic("recover");
`ifdef CAS_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
